// File: rtl/fetch_unit.sv
// ---------------------------------------------------------------------------
// FetchUnit (module fetch_unit)
//
// Purpose:
//   Instruction fetch front end. It holds the program counter, reads the
//   instruction memory combinationally at that PC, and queues {pc, instr}
//   pairs in a small FIFO that is presented to decode with a valid/ready
//   handshake. A redirect flushes the FIFO and restarts fetch at the
//   word-aligned target. A 32-bit counter records every completed handshake.
//
// Parameters:
//   RESET_PC : PC loaded on reset.
//   DEPTH    : number of fetch-buffer entries (power of two, >= 2).
//
// Ports:
//   clk             in   rising-edge clock
//   reset           in   synchronous active-high reset, overrides everything
//   fetch_en        in   allows new fetches
//   redirect_valid  in   branch/jump redirect request
//   redirect_pc     in   redirect target (low two bits ignored)
//   imem_addr       out  instruction memory address, equal to the current PC
//   imem_instr      in   instruction memory data for imem_addr, same cycle
//   out_valid       out  head entry valid toward decode
//   out_ready       in   decode accepts the head entry
//   out_instr       out  instruction of the head entry
//   out_pc          out  PC of the head entry
//   delivered_count out  completed out handshakes since reset (wraps)
// ---------------------------------------------------------------------------
module fetch_unit #(
  parameter logic [31:0] RESET_PC = 32'h0000_0000,
  parameter int          DEPTH    = 2
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        fetch_en,
  input  logic        redirect_valid,
  input  logic [31:0] redirect_pc,
  output logic [31:0] imem_addr,
  input  logic [31:0] imem_instr,
  output logic        out_valid,
  input  logic        out_ready,
  output logic [31:0] out_instr,
  output logic [31:0] out_pc,
  output logic [31:0] delivered_count
);

  localparam int PTR_W = $clog2(DEPTH);
  localparam int CNT_W = PTR_W + 1;

  localparam logic [PTR_W-1:0] PTR_ONE  = PTR_W'(1);
  localparam logic [CNT_W-1:0] CNT_ONE  = CNT_W'(1);
  localparam logic [CNT_W-1:0] CNT_FULL = CNT_W'(DEPTH);

  logic [31:0]      r_pc;
  logic [31:0]      r_instrMem [DEPTH];
  logic [31:0]      r_pcMem    [DEPTH];
  logic [PTR_W-1:0] r_headPtr;
  logic [PTR_W-1:0] r_tailPtr;
  logic [CNT_W-1:0] r_count;
  logic [31:0]      r_delivered;

  logic             w_pop;
  logic             w_fetch;

  // Handshake and fetch decisions for this cycle. A full buffer can still
  // accept a fetch when the head is leaving in the same cycle, which keeps
  // the pipeline streaming without a bubble. A redirect suppresses fetch
  // because the current PC is about to be abandoned.
  always_comb begin
    w_pop   = out_valid && out_ready;
    w_fetch = fetch_en && !redirect_valid && ((r_count != CNT_FULL) || w_pop);
  end

  // Outputs are read straight out of the registered FIFO storage at the
  // head pointer, so an entry appears the cycle after it was fetched and
  // stays put while decode stalls.
  always_comb begin
    imem_addr       = r_pc;
    out_valid       = (r_count != '0);
    out_instr       = r_instrMem[r_headPtr];
    out_pc          = r_pcMem[r_headPtr];
    delivered_count = r_delivered;
  end

  // All state. Reset wins over everything and also clears storage so the
  // outputs read as zero afterwards. Otherwise a pop is always counted as
  // delivered (decode already saw the entry, even under a redirect), then a
  // redirect flushes the queue and reloads the PC, and only without a
  // redirect do enqueue/dequeue and the occupancy update happen.
  always_ff @(posedge clk) begin
    if (reset) begin
      r_pc        <= RESET_PC;
      r_headPtr   <= '0;
      r_tailPtr   <= '0;
      r_count     <= '0;
      r_delivered <= '0;
      for (int i = 0; i < DEPTH; i++) begin
        r_instrMem[i] <= '0;
        r_pcMem[i]    <= '0;
      end
    end else begin
      if (w_pop) begin
        r_delivered <= r_delivered + 32'd1;
      end

      if (redirect_valid) begin
        r_pc      <= {redirect_pc[31:2], 2'b00};
        r_headPtr <= '0;
        r_tailPtr <= '0;
        r_count   <= '0;
      end else begin
        if (w_fetch) begin
          r_instrMem[r_tailPtr] <= imem_instr;
          r_pcMem[r_tailPtr]    <= r_pc;
          r_tailPtr             <= r_tailPtr + PTR_ONE;
          r_pc                  <= r_pc + 32'd4;
        end

        if (w_pop) begin
          r_headPtr <= r_headPtr + PTR_ONE;
        end

        case ({w_fetch, w_pop})
          2'b10:   r_count <= r_count + CNT_ONE;
          2'b01:   r_count <= r_count - CNT_ONE;
          default: r_count <= r_count;
        endcase
      end
    end
  end

endmodule

// File: tb/tb_fetch_unit.sv
// ---------------------------------------------------------------------------
// Testbench for fetch_unit.
//
// A reference model of the fetch front end (PC, a queue of expected
// {pc, instr} entries, a delivered counter) advances on every rising edge
// from the same inputs the DUT sees. A monitor on the falling edge compares
// the DUT's outputs with the model, and whenever the DUT shows a handshake
// it checks the presented entry against the head of the expected queue.
// RESET_PC is set near the top of the address space so the PC wrap is
// exercised right after reset.
// ---------------------------------------------------------------------------
module tb_fetch_unit;

  localparam logic [31:0] TB_RESET_PC = 32'hFFFF_FFF8;
  localparam int          TB_DEPTH    = 2;

  typedef struct packed {
    logic [31:0] pc;
    logic [31:0] instr;
  } entry_t;

  logic        clk;
  logic        reset;
  logic        fetch_en;
  logic        redirect_valid;
  logic [31:0] redirect_pc;
  logic [31:0] imem_addr;
  logic [31:0] imem_instr;
  logic        out_valid;
  logic        out_ready;
  logic [31:0] out_instr;
  logic [31:0] out_pc;
  logic [31:0] delivered_count;

  int errorCount = 0;
  int checkCount = 0;

  entry_t      expQ[$];
  logic [31:0] modelPc        = 32'h0;
  logic [31:0] modelDelivered = 32'h0;
  bit          modelLive      = 1'b0;
  bit          justReset      = 1'b0;

  fetch_unit #(
    .RESET_PC (TB_RESET_PC),
    .DEPTH    (TB_DEPTH)
  ) dut (
    .clk             (clk),
    .reset           (reset),
    .fetch_en        (fetch_en),
    .redirect_valid  (redirect_valid),
    .redirect_pc     (redirect_pc),
    .imem_addr       (imem_addr),
    .imem_instr      (imem_instr),
    .out_valid       (out_valid),
    .out_ready       (out_ready),
    .out_instr       (out_instr),
    .out_pc          (out_pc),
    .delivered_count (delivered_count)
  );

  // Free-running clock, period 10.
  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Instruction memory contents: the two known words at 0 and 4, elsewhere
  // a scrambled function of the address so every PC has a distinct word.
  function automatic logic [31:0] imemModel(input logic [31:0] addr);
    if (addr == 32'h0000_0000) return 32'h0000_0013;
    if (addr == 32'h0000_0004) return 32'h0010_0093;
    return {addr[15:0], addr[31:16]} ^ 32'h1357_9BDF;
  endfunction

  // Memory answers combinationally to whatever address the DUT drives.
  always_comb imem_instr = imemModel(imem_addr);

  // Reference model: on every rising edge apply the fetch rules to the
  // expected queue. Occupancy is simply the queue length.
  always @(posedge clk) begin
    int  sizeBefore;
    bit  popNow;
    if (reset) begin
      expQ.delete();
      modelPc        = TB_RESET_PC;
      modelDelivered = 32'h0;
      modelLive      = 1'b1;
      justReset      = 1'b1;
    end else if (modelLive) begin
      sizeBefore = expQ.size();
      popNow     = (sizeBefore != 0) && out_ready;
      if (popNow) begin
        void'(expQ.pop_front());
        modelDelivered = modelDelivered + 32'd1;
      end
      if (redirect_valid) begin
        expQ.delete();
        modelPc = redirect_pc & 32'hFFFF_FFFC;
      end else if (fetch_en && (sizeBefore < TB_DEPTH || popNow)) begin
        expQ.push_back('{pc: modelPc, instr: imemModel(modelPc)});
        modelPc = modelPc + 32'd4;
      end
    end
  end

  task automatic checkOutput(input string name, input logic [31:0] actual,
                             input logic [31:0] expected);
    checkCount++;
    if (actual !== expected) begin
      errorCount++;
      $display("[TB] FAIL %s: got %08h expected %08h at %0t", name, actual, expected, $time);
    end
  endtask

  // Monitor: compares the DUT against the model away from the active edge.
  always @(negedge clk) begin
    if (modelLive) begin
      checkOutput("out_valid", {31'b0, out_valid}, {31'b0, (expQ.size() != 0)});
      checkOutput("imem_addr", imem_addr, modelPc);
      checkOutput("delivered_count", delivered_count, modelDelivered);
      if (justReset) begin
        checkOutput("reset_out_instr", out_instr, 32'h0);
        checkOutput("reset_out_pc", out_pc, 32'h0);
        justReset = 1'b0;
      end
      if (out_valid && expQ.size() != 0) begin
        checkOutput("out_pc", out_pc, expQ[0].pc);
        checkOutput("out_instr", out_instr, expQ[0].instr);
      end
    end
  end

  // Drive one cycle of inputs shortly after the falling edge, so the
  // monitor has already sampled and the next rising edge sees them stable.
  task automatic applyStimulus(input logic rst, input logic fe, input logic rv,
                               input logic [31:0] rpc, input logic rdy);
    @(negedge clk);
    #1;
    reset          = rst;
    fetch_en       = fe;
    redirect_valid = rv;
    redirect_pc    = rpc;
    out_ready      = rdy;
  endtask

  initial begin
    reset          = 1'b1;
    fetch_en       = 1'b0;
    redirect_valid = 1'b0;
    redirect_pc    = 32'h0;
    out_ready      = 1'b0;

    // Reset, then free-run across the top of the address space.
    applyStimulus(1, 0, 0, 32'h0, 0);
    applyStimulus(1, 0, 0, 32'h0, 0);
    for (int i = 0; i < 6; i++) applyStimulus(0, 1, 0, 32'h0, 1);

    // Restart at address 0 and stream the two known instructions.
    applyStimulus(0, 1, 1, 32'h0, 1);
    for (int i = 0; i < 4; i++) applyStimulus(0, 1, 0, 32'h0, 1);

    // Decode stalled: buffer fills, PC holds, then drains in order.
    applyStimulus(0, 1, 1, 32'h0, 0);
    for (int i = 0; i < 4; i++) applyStimulus(0, 1, 0, 32'h0, 0);
    for (int i = 0; i < 4; i++) applyStimulus(0, 1, 0, 32'h0, 1);

    // Full buffer, redirect to an unaligned target while popping.
    for (int i = 0; i < 3; i++) applyStimulus(0, 1, 0, 32'h0, 0);
    applyStimulus(0, 1, 1, 32'h0000_0102, 1);
    for (int i = 0; i < 3; i++) applyStimulus(0, 1, 0, 32'h0, 1);

    // fetch_en toggling every cycle with decode always ready.
    for (int i = 0; i < 12; i++) applyStimulus(0, i[0], 0, 32'h0, 1);

    // Randomized traffic, including occasional redirects and resets.
    for (int i = 0; i < 400; i++) begin
      applyStimulus(($urandom_range(63) == 0),
                    ($urandom_range(3) != 0),
                    ($urandom_range(15) == 0),
                    $urandom(),
                    ($urandom_range(2) != 0));
    end

    // Two entries buffered, then reset together with a redirect.
    applyStimulus(0, 1, 1, 32'h0000_0040, 0);
    for (int i = 0; i < 3; i++) applyStimulus(0, 1, 0, 32'h0, 0);
    applyStimulus(1, 1, 1, 32'h0000_0200, 1);
    for (int i = 0; i < 4; i++) applyStimulus(0, 1, 0, 32'h0, 1);

    @(negedge clk);
    #1;
    $display("Result: errors=%0d of %0d checks", errorCount, checkCount);
    $finish;
  end

endmodule

// File: doc/fetch_unit.md
FETCH_UNIT -- requirements
Module: fetch_unit

Interface
REQ-001 The module SHALL have one clock and a synchronous, active-high reset.
REQ-002 Parameter RESET_PC, default 32'h0000_0000, SHALL be the PC value loaded on reset.
REQ-003 Parameter DEPTH, default 2, SHALL be the fetch-buffer entry count; legal values are powers of two >= 2.
REQ-004 clk  input  1  rising-edge clock; all state updates on this edge.
REQ-005 reset  input  1  synchronous active-high reset.
REQ-006 fetch_en  input  1  permits new fetches when high.
REQ-007 redirect_valid  input  1  branch/jump redirect request.
REQ-008 redirect_pc  input  32  redirect target address.
REQ-009 imem_addr  output  32  address to instruction memory; combinationally equal to current PC.
REQ-010 imem_instr  input  32  instruction memory read data; combinational response to imem_addr in the same cycle.
REQ-011 out_valid  output  1  head buffer entry valid toward decode.
REQ-012 out_ready  input  1  decode accepts head entry.
REQ-013 out_instr  output  32  instruction of head entry.
REQ-014 out_pc  output  32  PC of head entry.
REQ-015 delivered_count  output  32  number of completed out handshakes since reset.

Function
REQ-016 pop SHALL be defined as out_valid && out_ready; fetch SHALL be defined as fetch_en && !redirect_valid && (count < DEPTH || pop).
REQ-017 On fetch, the buffer SHALL enqueue {pc, imem_instr} at the tail and pc SHALL become pc + 4 modulo 2^32 (32'hFFFF_FFFC wraps to 32'h0000_0000).
REQ-018 Without fetch or redirect, pc SHALL hold.
REQ-019 Buffer SHALL be FIFO ordered; out_instr/out_pc SHALL come from registered storage at the head pointer, giving 1-cycle latency from fetch to out_valid.
REQ-020 out_valid SHALL equal (count != 0).
REQ-021 count update: +1 on fetch without pop, -1 on pop without fetch, unchanged on both or neither.
REQ-022 Full buffer (count == DEPTH) with no pop: no fetch, pc holds, imem_addr stable.
REQ-023 Full buffer with pop in the same cycle: fetch occurs and count stays DEPTH.
REQ-024 Head/tail pointers SHALL be log2(DEPTH) bits and wrap modulo DEPTH.
REQ-025 On redirect_valid, the next edge SHALL set pc <= {redirect_pc[31:2], 2'b00}, count <= 0, and head/tail <= 0; all buffered entries are discarded.
REQ-026 Redirect SHALL take priority over fetch and pop in the same cycle: no enqueue, and the popped entry (if any) still counts as delivered since decode saw it.
REQ-027 The cycle after a redirect, out_valid SHALL be 0 and imem_addr SHALL equal the aligned redirect target.
REQ-028 delivered_count SHALL increment by 1 on every pop, wrapping modulo 2^32.
REQ-029 fetch_en low SHALL stop enqueues only; pops and redirects continue to operate.
REQ-030 out_instr/out_pc SHALL hold stable while out_valid && !out_ready.

Reset
REQ-031 Reset SHALL override every other input, including redirect and pop.
REQ-032 On reset: pc = RESET_PC, count = 0, head = tail = 0, all storage = 0, delivered_count = 0.
REQ-033 After reset: out_valid = 0, out_instr = 0, out_pc = 0, imem_addr = RESET_PC.
REQ-034 Reset asserted mid-stream SHALL discard all buffered entries, with outputs per REQ-033 on the following cycle.

Verification
REQ-035 Reset, then fetch_en=1, out_ready=1, imem returning 32'h0000_0013 at 0 and 32'h0010_0093 at 4 -> out (pc=0, 0x00000013) one cycle after first fetch, then (pc=4, 0x00100093); delivered_count=2.
REQ-036 out_ready=0, fetch_en=1, DEPTH=2 -> after 2 cycles count=2, imem_addr holds at 8; raising out_ready delivers pc 0, 4, 8 in order, no gaps.
REQ-037 Buffer full, and in one cycle out_ready=1 and redirect_pc=32'h0000_0102 -> next cycle out_valid=0, imem_addr=32'h0000_0100, delivered_count +1; following fetch emits out_pc=0x100.
REQ-038 RESET_PC=32'hFFFF_FFF8, free-running fetch -> out_pc sequence FFFF_FFF8, FFFF_FFFC, 0000_0000.
REQ-039 Reset asserted with 2 entries buffered and redirect_valid=1 -> next cycle out_valid=0, imem_addr=RESET_PC, delivered_count=0.
REQ-040 fetch_en toggled every cycle with out_ready=1 -> each PC emitted exactly once, in increasing order, no duplicates or drops.
